dmac_channel_arbiter: RTL and testbench

- Arbitrates NUM_REQ peripheral DMA request lines onto the single DMAC transfer engine.
- Picks a winner by fixed or round-robin priority, then runs the bus request/grant handshake with the AHB arbiter.
- Enables the channel once the slave side is configured, and retires the transfer on channel completion.
- Sits between the peripheral request pins and the DMAC main control / channel datapath, with a grant-timeout watchdog.

---
 rtl/dmac_pkg.sv | 6 +
 rtl/dmac_rr_picker.sv | 34 +++
 rtl/dmac_channel_arbiter.sv | 116 +++++++++++
 tb/tb_dmac_channel_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_pkg.sv
// dmac_pkg: shared state type and priority-mode constants for the DMAC channel arbiter
package dmac_pkg;
  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} arb_state_t;
  localparam logic PRIO_FIXED = 1'b0;
  localparam logic PRIO_RR = 1'b1;
endpackage

// File: rtl/dmac_rr_picker.sv
// dmac_rr_picker: combinational winner select, highest index (fixed) or first set bit from start upward (round-robin)
module dmac_rr_picker
  import dmac_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int REQ_W = $clog2(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   start,
  input  logic               mode,
  output logic [REQ_W-1:0]   win,
  output logic               valid
);
  logic [REQ_W:0] sum;
  logic [REQ_W-1:0] idx;
  logic found;
  always_comb begin
    win = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, start} + (REQ_W+1)'(i);
      idx = (mode == PRIO_FIXED) ? REQ_W'(i) :
            (sum >= (REQ_W+1)'(NUM_REQ)) ? REQ_W'(sum - (REQ_W+1)'(NUM_REQ)) : sum[REQ_W-1:0];
      // fixed mode lets later (higher) indices overwrite; rr mode keeps the first hit
      if (req[idx] && (mode == PRIO_FIXED || !found)) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign valid = |req;
endmodule

// File: rtl/dmac_channel_arbiter.sv
// dmac_channel_arbiter: picks a DMA requester, runs the AHB request/grant handshake and retires the transfer
module dmac_channel_arbiter
  import dmac_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int REQ_W = $clog2(NUM_REQ),
  parameter int GRANT_TIMEOUT = 255,
  parameter int TO_W = 8
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] DmacReq,
  input  logic               prio_mode,
  input  logic               Bus_Grant,
  input  logic               C_config,
  input  logic               xfer_done,
  output logic               Bus_Req,
  output logic               Channel_en,
  output logic [NUM_REQ-1:0] ReqAck,
  output logic [REQ_W-1:0]   active_id,
  output logic               busy,
  output logic               Interrupt,
  output logic               timeout_err
);
  arb_state_t state, state_n;
  logic [TO_W-1:0] cnt, cnt_n, cnt_inc;
  logic [REQ_W-1:0] rr_ptr, rr_n, id_n, win, ptr_after;
  logic [NUM_REQ-1:0] ack_n;
  logic valid, bus_req_n, chen_n, irq_n, to_n, busy_n;

  dmac_rr_picker #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) u_picker (
    .req(DmacReq), .start(rr_ptr), .mode(prio_mode), .win(win), .valid(valid)
  );

  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  assign ptr_after = (active_id == REQ_W'(NUM_REQ-1)) ? '0 : active_id + 1'b1;

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    rr_n = rr_ptr;
    id_n = active_id;
    bus_req_n = 1'b0;
    busy_n = 1'b0;
    chen_n = 1'b0;
    ack_n = '0;
    irq_n = 1'b0;
    to_n = 1'b0;
    case (state)
      IDLE: if (valid) begin
        state_n = REQ;
        id_n = win;
        cnt_n = '0;
        bus_req_n = 1'b1;
        busy_n = 1'b1;
      end
      REQ: begin
        bus_req_n = 1'b1;
        busy_n = 1'b1;
        cnt_n = cnt_inc;
        // grant beats both withdrawal and timeout in the same cycle
        if (Bus_Grant && C_config) begin
          state_n = XFER;
          chen_n = 1'b1;
          ack_n = NUM_REQ'(1) << active_id;
        end else if (!DmacReq[active_id]) begin
          state_n = IDLE;
          bus_req_n = 1'b0;
          busy_n = 1'b0;
        end else if (cnt_inc >= TO_W'(GRANT_TIMEOUT)) begin
          state_n = IDLE;
          bus_req_n = 1'b0;
          busy_n = 1'b0;
          to_n = 1'b1;
          rr_n = ptr_after;
        end
      end
      XFER: begin
        busy_n = 1'b1;
        bus_req_n = !xfer_done;
        irq_n = xfer_done;
        state_n = xfer_done ? DONE : XFER;
      end
      DONE: begin
        rr_n = ptr_after;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      rr_ptr <= '0;
      active_id <= '0;
      Bus_Req <= 1'b0;
      busy <= 1'b0;
      Channel_en <= 1'b0;
      ReqAck <= '0;
      Interrupt <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rr_ptr <= rr_n;
      active_id <= id_n;
      Bus_Req <= bus_req_n;
      busy <= busy_n;
      Channel_en <= chen_n;
      ReqAck <= ack_n;
      Interrupt <= irq_n;
      timeout_err <= to_n;
    end
  end
endmodule

// File: tb/tb_dmac_channel_arbiter.sv
// tb_dmac_channel_arbiter: directed scenario tests for the DMAC channel arbiter
module tb_dmac_channel_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] DmacReq = '0, ReqAck;
  logic prio_mode = 1'b0, Bus_Grant = 1'b0, C_config = 1'b0, xfer_done = 1'b0;
  logic Bus_Req, Channel_en, busy, Interrupt, timeout_err;
  logic [1:0] active_id;
  int checks = 0, failures = 0;

  dmac_channel_arbiter #(.NUM_REQ(4), .GRANT_TIMEOUT(8), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .DmacReq(DmacReq), .prio_mode(prio_mode),
    .Bus_Grant(Bus_Grant), .C_config(C_config), .xfer_done(xfer_done),
    .Bus_Req(Bus_Req), .Channel_en(Channel_en), .ReqAck(ReqAck), .active_id(active_id),
    .busy(busy), .Interrupt(Interrupt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset;
    rst = 1'b0;
    DmacReq = '0; prio_mode = 1'b0; Bus_Grant = 1'b0; C_config = 1'b0; xfer_done = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    cyc(2);
    checks++;
    if ({Bus_Req, busy, Channel_en, Interrupt, timeout_err, ReqAck, active_id} !== 11'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {Bus_Req, busy, Channel_en, Interrupt, timeout_err, ReqAck, active_id});
    end
    rst = 1'b1;
    cyc(2);
    checks++;
    if ({Bus_Req, busy} !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=00", {Bus_Req, busy});
    end
  endtask

  task automatic test_fixed;
    apply_reset;
    DmacReq = 4'b0101;
    cyc(1);
    checks++;
    if ({Bus_Req, busy, active_id, ReqAck} !== 8'b11_10_0000) begin
      failures++;
      $display("FAIL fixed_req got=%b exp=11100000", {Bus_Req, busy, active_id, ReqAck});
    end
    cyc(2);
    Bus_Grant = 1'b1; C_config = 1'b1;
    cyc(1);
    checks++;
    if ({Channel_en, ReqAck} !== 5'b1_0100) begin
      failures++;
      $display("FAIL fixed_ack got=%b exp=10100", {Channel_en, ReqAck});
    end
    Bus_Grant = 1'b0; C_config = 1'b0; DmacReq = '0;
    cyc(1);
    checks++;
    if ({Channel_en, ReqAck, Bus_Req, busy} !== 7'b0_0000_11) begin
      failures++;
      $display("FAIL fixed_hold got=%b exp=0000011", {Channel_en, ReqAck, Bus_Req, busy});
    end
    xfer_done = 1'b1;
    cyc(1);
    xfer_done = 1'b0;
    checks++;
    if ({Interrupt, Bus_Req, busy} !== 3'b101) begin
      failures++;
      $display("FAIL fixed_done got=%b exp=101", {Interrupt, Bus_Req, busy});
    end
    cyc(1);
    checks++;
    if ({Interrupt, Bus_Req, busy} !== 3'b000) begin
      failures++;
      $display("FAIL fixed_idle got=%b exp=000", {Interrupt, Bus_Req, busy});
    end
  endtask

  task automatic test_round_robin;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_ack;
    int n, g;
    apply_reset;
    prio_mode = 1'b1; DmacReq = 4'b1111; Bus_Grant = 1'b1; C_config = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (ReqAck === 4'b0 && n < 20) begin
        cyc(1);
        n++;
      end
      exp_ack = 4'b0001 << order[k];
      checks++;
      if (ReqAck !== exp_ack) begin
        failures++;
        $display("FAIL rr_ack%0d got=%b exp=%b", k, ReqAck, exp_ack);
      end
      cyc(4);
      xfer_done = 1'b1;
      cyc(1);
      xfer_done = 1'b0;
      g = 0;
      while (!Bus_Req && g < 10) begin
        g++;
        cyc(1);
      end
      checks++;
      if (g < 1 || g > 2) begin
        failures++;
        $display("FAIL rr_gap%0d got=%0d exp=1..2", k, g);
      end
    end
  endtask

  task automatic test_timeout;
    int n;
    logic acked;
    apply_reset;
    prio_mode = 1'b1; DmacReq = 4'b0010;
    cyc(1);
    n = 0;
    acked = 1'b0;
    while (Bus_Req && n < 20) begin
      n++;
      if (ReqAck !== 4'b0 || Channel_en) acked = 1'b1;
      cyc(1);
    end
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL to_req_cycles got=%0d exp=8", n);
    end
    checks++;
    if ({timeout_err, Bus_Req, acked} !== 3'b100) begin
      failures++;
      $display("FAIL to_pulse got=%b exp=100", {timeout_err, Bus_Req, acked});
    end
    DmacReq = 4'b0011;
    cyc(1);
    checks++;
    if ({busy, active_id, timeout_err} !== 4'b1_00_0) begin
      failures++;
      $display("FAIL to_next_winner got=%b exp=1000", {busy, active_id, timeout_err});
    end
    DmacReq = '0;
    cyc(2);
  endtask

  task automatic test_withdraw;
    apply_reset;
    DmacReq = 4'b1000;
    cyc(1);
    checks++;
    if ({Bus_Req, busy, active_id} !== 4'b11_11) begin
      failures++;
      $display("FAIL wd_req got=%b exp=1111", {Bus_Req, busy, active_id});
    end
    cyc(1);
    DmacReq = '0;
    cyc(1);
    checks++;
    if ({busy, Bus_Req, ReqAck, Channel_en} !== 7'b0) begin
      failures++;
      $display("FAIL wd_abort got=%b exp=0000000", {busy, Bus_Req, ReqAck, Channel_en});
    end
  endtask

  task automatic test_grant_wo_config;
    logic seen;
    apply_reset;
    DmacReq = 4'b0001;
    cyc(1);
    Bus_Grant = 1'b1; C_config = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      cyc(1);
      if (Channel_en || ReqAck !== 4'b0) seen = 1'b1;
    end
    checks++;
    if ({seen, Bus_Req} !== 2'b01) begin
      failures++;
      $display("FAIL gwc_wait got=%b exp=01", {seen, Bus_Req});
    end
    C_config = 1'b1;
    cyc(1);
    checks++;
    if ({Channel_en, ReqAck} !== 5'b1_0001) begin
      failures++;
      $display("FAIL gwc_start got=%b exp=10001", {Channel_en, ReqAck});
    end
    Bus_Grant = 1'b0; C_config = 1'b0; DmacReq = 4'b1001;
    seen = 1'b0;
    repeat (3) begin
      cyc(1);
      if (active_id !== 2'd0 || ReqAck !== 4'b0 || !Bus_Req || Channel_en) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL gwc_no_preempt got=%b exp=0", seen);
    end
    xfer_done = 1'b1;
    cyc(1);
    xfer_done = 1'b0;
    cyc(2);
    checks++;
    if ({busy, active_id} !== 3'b1_11) begin
      failures++;
      $display("FAIL gwc_next_owner got=%b exp=111", {busy, active_id});
    end
    DmacReq = '0;
    cyc(2);
  endtask

  task automatic test_async_reset;
    logic irq;
    apply_reset;
    prio_mode = 1'b1; DmacReq = 4'b0100; Bus_Grant = 1'b1; C_config = 1'b1;
    cyc(2);
    DmacReq = '0; Bus_Grant = 1'b0; C_config = 1'b0;
    cyc(1);
    xfer_done = 1'b1;
    cyc(1);
    xfer_done = 1'b0;
    cyc(2);
    DmacReq = 4'b1000; Bus_Grant = 1'b1; C_config = 1'b1;
    cyc(2);
    checks++;
    if (ReqAck !== 4'b1000) begin
      failures++;
      $display("FAIL ar_second_ack got=%b exp=1000", ReqAck);
    end
    DmacReq = '0; Bus_Grant = 1'b0; C_config = 1'b0;
    cyc(1);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({Bus_Req, busy, Channel_en, Interrupt, timeout_err, ReqAck, active_id} !== 11'b0) begin
      failures++;
      $display("FAIL ar_immediate got=%b exp=0", {Bus_Req, busy, Channel_en, Interrupt, timeout_err, ReqAck, active_id});
    end
    xfer_done = 1'b1;
    cyc(1);
    rst = 1'b1; xfer_done = 1'b0;
    irq = 1'b0;
    repeat (3) begin
      cyc(1);
      if (Interrupt || busy) irq = 1'b1;
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL ar_no_irq got=%b exp=0", irq);
    end
    DmacReq = 4'b1010;
    cyc(1);
    checks++;
    if ({busy, active_id} !== 3'b1_01) begin
      failures++;
      $display("FAIL ar_rr_restart got=%b exp=101", {busy, active_id});
    end
    DmacReq = '0;
    cyc(2);
  endtask

  initial begin
    test_reset;
    test_fixed;
    test_round_robin;
    test_timeout;
    test_withdraw;
    test_grant_wo_config;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
